// File: rtl/board_mem_streamer_pkg.sv
// board_mem_pkg: shared widths, FSM state type and RAM write-side tie-offs for board_mem_streamer
package board_mem_pkg;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W = 12;
  localparam int DEF_FIFO_DEPTH = 4;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_e;
  localparam logic [3:0] BE_TIE = 4'hF;
  localparam logic [DEF_DATA_W-1:0] WDATA_TIE = '0;
endpackage

// File: rtl/board_mem_streamer_if.sv
// board_mem_streamer_if: command, RAM (Avalon read) and output-stream signals of the streamer
// master = streamer side (drives cmd_ready, mem_*, out_*, busy, done); slave = environment side
interface board_mem_streamer_if import board_mem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W = DEF_LEN_W
);
  logic cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0] cmd_len;
  logic [ADDR_W-1:0] mem_address;
  logic mem_chipselect, mem_clken, mem_write;
  logic [3:0] mem_byteenable;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;
  logic out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;
  logic busy, done;
  modport master (
    input cmd_valid, cmd_base, cmd_len, mem_readdata, out_ready,
    output cmd_ready, mem_address, mem_chipselect, mem_clken, mem_write, mem_byteenable,
    output mem_writedata, out_valid, out_data, out_last, busy, done
  );
  modport slave (
    output cmd_valid, cmd_base, cmd_len, mem_readdata, out_ready,
    input cmd_ready, mem_address, mem_chipselect, mem_clken, mem_write, mem_byteenable,
    input mem_writedata, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/board_mem_streamer_fifo.sv
// stream_fifo: synchronous FIFO with combinational head and registered occupancy count
// ports: push_i/data_i write side, pop_i/head_o read side, count_o current occupancy
module stream_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  assign head_o = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= data_i;
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/board_mem_streamer.sv
// board_mem_streamer: streams a (base,len) window of the board RAM onto a valid/ready output
// ports: clk, reset (sync, active-high), bus = command, RAM read and output stream (master side)
module board_mem_streamer import board_mem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic clk,
  input logic reset,
  board_mem_streamer_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0] rem_q;
  logic pend_q, pend_last_q, done_q;
  logic [CW-1:0] count;
  logic [DATA_W:0] head;
  logic cmd_fire, issue, last_issue, pop, head_last;
  assign cmd_fire = state_q == S_IDLE && bus.cmd_valid;
  // credit counts the buffered words plus the read still in the RAM pipeline
  assign issue = !reset && state_q == S_RUN
    && ({1'b0, count} + (CW+1)'(pend_q)) < (CW+1)'(FIFO_DEPTH);
  assign last_issue = issue && rem_q == LEN_W'(1);
  assign pop = count != '0 && bus.out_ready;
  assign head_last = head[DATA_W];
  always_comb
    state_d = state_q == S_IDLE ? ((cmd_fire && bus.cmd_len != '0) ? S_RUN : S_IDLE)
            : state_q == S_RUN  ? (last_issue ? S_DRAIN : S_RUN)
            : ((pop && head_last) ? S_IDLE : S_DRAIN);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      rem_q <= '0;
      pend_q <= 1'b0;
      pend_last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= issue;
      pend_last_q <= last_issue;
      done_q <= (cmd_fire && bus.cmd_len == '0) || (pop && head_last);
      if (cmd_fire) begin
        addr_q <= bus.cmd_base;
        rem_q <= bus.cmd_len;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q <= rem_q - LEN_W'(1);
      end
    end
  end
  stream_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(pend_q),
    .data_i({pend_last_q, bus.mem_readdata}),
    .pop_i(pop),
    .head_o(head),
    .count_o(count)
  );
  assign bus.cmd_ready = state_q == S_IDLE;
  assign bus.busy = state_q != S_IDLE;
  assign bus.done = done_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_chipselect = issue;
  assign bus.mem_clken = !reset;
  assign bus.mem_write = 1'b0;
  assign bus.mem_byteenable = BE_TIE;
  assign bus.mem_writedata = DATA_W'(WDATA_TIE);
  assign bus.out_valid = count != '0;
  assign bus.out_data = head[DATA_W-1:0];
  assign bus.out_last = bus.out_valid && head_last;
endmodule
